// File: rtl/processor_status_reg.sv
// ---------------------------------------------------------------------------
// processor_status_reg
//
// 6502 / 2A03 processor status register (P) for the cpu6502 core.
// Holds the C, Z, I, D, V and N flags. Each flag has its own load sources,
// and those sources are resolved by a fixed priority. All flags update on
// rising i_clk when i_clk_en (the phi2 qualifier) is high. Bits 5 and 4 are
// not stored: bit 5 always reads as 1. In the pushed byte, bit 4 carries B.
//
// Parameters
//   HAS_DECIMAL : 1 = D flag drives o_decimal_en, 0 = 2A03 (D stored only)
//   RESET_P     : flag values loaded while i_reset_n is low (bits 5/4 unused)
//   DB_WIDTH    : internal data bus width, must be 8
//
// Ports
//   i_clk, i_reset_n   : core clock, asynchronous active-low reset
//   i_clk_en           : update enable; flags hold when low
//   i_db               : internal data bus
//   i_acr, i_avr       : ALU carry out / ALU overflow
//   i_ir5              : IR bit 5 (set/clear value for SEC/CLC, SEI/CLI, SED/CLD)
//   i_db0_c..i_db7_n   : per-flag load selects (see priority chains below)
//   i_so_n             : SO pin; a falling edge sets V
//   i_brk_push         : B bit value placed in o_p_push
//   o_p                : {N,V,1,1,D,I,Z,C}
//   o_p_push           : {N,V,1,B,D,I,Z,C} for a stack push
//   o_decimal_en       : D && HAS_DECIMAL
// ---------------------------------------------------------------------------
module processor_status_reg #(
  parameter bit         HAS_DECIMAL = 1'b1,
  parameter logic [7:0] RESET_P     = 8'h04,
  parameter int         DB_WIDTH    = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clk_en,
  input  logic [DB_WIDTH-1:0] i_db,
  input  logic                i_acr,
  input  logic                i_avr,
  input  logic                i_ir5,
  input  logic                i_db0_c,
  input  logic                i_ir5_c,
  input  logic                i_acr_c,
  input  logic                i_db1_z,
  input  logic                i_dbz_z,
  input  logic                i_db2_i,
  input  logic                i_ir5_i,
  input  logic                i_set_i,
  input  logic                i_db3_d,
  input  logic                i_ir5_d,
  input  logic                i_db6_v,
  input  logic                i_avr_v,
  input  logic                i_0_v,
  input  logic                i_so_n,
  input  logic                i_db7_n,
  input  logic                i_brk_push,
  output logic [7:0]          o_p,
  output logic [7:0]          o_p_push,
  output logic                o_decimal_en
);

  // The flag bit positions are hard-wired to an 8-bit bus, so any other
  // width is rejected at elaboration.
  if (DB_WIDTH != 8) begin : g_bad_db_width
    $error("processor_status_reg: DB_WIDTH must be 8");
  end

  // Stored flags
  logic c_r;
  logic z_r;
  logic i_r;
  logic d_r;
  logic v_r;
  logic n_r;

  // Next-state values (selected by priority, hold when nothing is selected)
  logic c_nxt_s;
  logic z_nxt_s;
  logic i_nxt_s;
  logic d_nxt_s;
  logic v_nxt_s;
  logic n_nxt_s;

  // SO pin synchroniser, edge detector and pending-event flag
  logic so_sync1_r;
  logic so_sync2_r;
  logic so_prev_r;
  logic so_pend_r;
  logic so_fall_s;
  logic so_event_s;
  logic so_pend_nxt_s;

  logic db_zero_s;

  // PLP drives all of db, but bits 5 and 4 have no storage behind them.
  logic unused_db_s;
  assign unused_db_s = i_db[5] ^ i_db[4];

  assign db_zero_s = (i_db == {DB_WIDTH{1'b0}});

  // ------------------------------------------------------------------------
  // SO handling. i_so_n is asynchronous to the core, so it is passed through
  // two flops before edge detection. The synchroniser runs every clock,
  // whether or not i_clk_en is high. This means a short SO pulse during a
  // stalled phase is not lost.
  // ------------------------------------------------------------------------
  assign so_fall_s = so_prev_r & ~so_sync2_r;

  // The event remains visible until an enabled edge consumes it. A fall
  // that arrives in the same cycle as an enabled edge is consumed at once.
  assign so_event_s = so_pend_r | so_fall_s;

  // Pending flag: cleared by an enabled edge, otherwise it accumulates falls
  // (a second fall merges into the first one).
  always_comb begin
    so_pend_nxt_s = so_pend_r;
    if (i_clk_en) begin
      so_pend_nxt_s = 1'b0;
    end else begin
      so_pend_nxt_s = so_pend_r | so_fall_s;
    end
  end

  // SO synchroniser / edge / pending registers; idle level of the pin is high
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      so_sync1_r <= 1'b1;
      so_sync2_r <= 1'b1;
      so_prev_r  <= 1'b1;
      so_pend_r  <= 1'b0;
    end else begin
      so_sync1_r <= i_so_n;
      so_sync2_r <= so_sync1_r;
      so_prev_r  <= so_sync2_r;
      so_pend_r  <= so_pend_nxt_s;
    end
  end

  // ------------------------------------------------------------------------
  // Per-flag load selection. Each chain is independent, so a single cycle
  // can update any combination of flags (PLP asserts every db select).
  // ------------------------------------------------------------------------

  // C: db[0] > ALU carry > IR bit 5
  always_comb begin
    c_nxt_s = c_r;
    if (i_db0_c) begin
      c_nxt_s = i_db[0];
    end else if (i_acr_c) begin
      c_nxt_s = i_acr;
    end else if (i_ir5_c) begin
      c_nxt_s = i_ir5;
    end else begin
      c_nxt_s = c_r;
    end
  end

  // Z: db[1] > (db == 0)
  always_comb begin
    z_nxt_s = z_r;
    if (i_db1_z) begin
      z_nxt_s = i_db[1];
    end else if (i_dbz_z) begin
      z_nxt_s = db_zero_s;
    end else begin
      z_nxt_s = z_r;
    end
  end

  // I: forced set (interrupt entry) > db[2] > IR bit 5
  always_comb begin
    i_nxt_s = i_r;
    if (i_set_i) begin
      i_nxt_s = 1'b1;
    end else if (i_db2_i) begin
      i_nxt_s = i_db[2];
    end else if (i_ir5_i) begin
      i_nxt_s = i_ir5;
    end else begin
      i_nxt_s = i_r;
    end
  end

  // D: db[3] > IR bit 5
  always_comb begin
    d_nxt_s = d_r;
    if (i_db3_d) begin
      d_nxt_s = i_db[3];
    end else if (i_ir5_d) begin
      d_nxt_s = i_ir5;
    end else begin
      d_nxt_s = d_r;
    end
  end

  // V: SO event > db[6] > ALU overflow > clear (CLV)
  always_comb begin
    v_nxt_s = v_r;
    if (so_event_s) begin
      v_nxt_s = 1'b1;
    end else if (i_db6_v) begin
      v_nxt_s = i_db[6];
    end else if (i_avr_v) begin
      v_nxt_s = i_avr;
    end else if (i_0_v) begin
      v_nxt_s = 1'b0;
    end else begin
      v_nxt_s = v_r;
    end
  end

  // N: db[7] only
  always_comb begin
    n_nxt_s = n_r;
    if (i_db7_n) begin
      n_nxt_s = i_db[7];
    end else begin
      n_nxt_s = n_r;
    end
  end

  // Flag storage: reset to RESET_P, update only on enabled edges
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      c_r <= RESET_P[0];
      z_r <= RESET_P[1];
      i_r <= RESET_P[2];
      d_r <= RESET_P[3];
      v_r <= RESET_P[6];
      n_r <= RESET_P[7];
    end else if (i_clk_en) begin
      c_r <= c_nxt_s;
      z_r <= z_nxt_s;
      i_r <= i_nxt_s;
      d_r <= d_nxt_s;
      v_r <= v_nxt_s;
      n_r <= n_nxt_s;
    end
  end

  // Outputs are taken directly from the flag flops. The only input that
  // reaches an output is i_brk_push, which supplies the B bit of the pushed byte.
  assign o_p          = {n_r, v_r, 1'b1, 1'b1, d_r, i_r, z_r, c_r};
  assign o_p_push     = {n_r, v_r, 1'b1, i_brk_push, d_r, i_r, z_r, c_r};
  assign o_decimal_en = d_r & HAS_DECIMAL;

endmodule

// File: tb/tb_processor_status_reg.sv
// ---------------------------------------------------------------------------
// tb_processor_status_reg
//
// Self-checking bench for processor_status_reg. Each driven cycle pushes the
// expected o_p into exp_q, and the o_p value sampled after the edge goes
// into obs_q. Each test task then drains both queues and compares them.
// A second instance built with HAS_DECIMAL=0 shares the same inputs.
// ---------------------------------------------------------------------------
module tb_processor_status_reg;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_clk_en;
  logic [7:0] i_db;
  logic       i_acr, i_avr, i_ir5;
  logic       i_db0_c, i_ir5_c, i_acr_c;
  logic       i_db1_z, i_dbz_z;
  logic       i_db2_i, i_ir5_i, i_set_i;
  logic       i_db3_d, i_ir5_d;
  logic       i_db6_v, i_avr_v, i_0_v, i_so_n;
  logic       i_db7_n;
  logic       i_brk_push;
  logic [7:0] o_p, o_p_push;
  logic       o_decimal_en;
  logic [7:0] o_p_nd, o_p_push_nd;
  logic       o_decimal_en_nd;

  // Select vector bit positions
  localparam logic [13:0] S_C_DB0 = 14'h0001;
  localparam logic [13:0] S_C_IR5 = 14'h0002;
  localparam logic [13:0] S_C_ACR = 14'h0004;
  localparam logic [13:0] S_Z_DB1 = 14'h0008;
  localparam logic [13:0] S_Z_DBZ = 14'h0010;
  localparam logic [13:0] S_I_DB2 = 14'h0020;
  localparam logic [13:0] S_I_IR5 = 14'h0040;
  localparam logic [13:0] S_I_SET = 14'h0080;
  localparam logic [13:0] S_D_DB3 = 14'h0100;
  localparam logic [13:0] S_D_IR5 = 14'h0200;
  localparam logic [13:0] S_V_DB6 = 14'h0400;
  localparam logic [13:0] S_V_AVR = 14'h0800;
  localparam logic [13:0] S_V_0   = 14'h1000;
  localparam logic [13:0] S_N_DB7 = 14'h2000;
  localparam logic [13:0] S_NONE  = 14'h0000;
  localparam logic [13:0] S_DBALL = S_C_DB0 | S_Z_DB1 | S_I_DB2 | S_D_DB3 | S_V_DB6 | S_N_DB7;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] want_v;
  logic [7:0] got_v;

  processor_status_reg dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en), .i_db(i_db),
    .i_acr(i_acr), .i_avr(i_avr), .i_ir5(i_ir5),
    .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c), .i_acr_c(i_acr_c),
    .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z),
    .i_db2_i(i_db2_i), .i_ir5_i(i_ir5_i), .i_set_i(i_set_i),
    .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
    .i_db6_v(i_db6_v), .i_avr_v(i_avr_v), .i_0_v(i_0_v), .i_so_n(i_so_n),
    .i_db7_n(i_db7_n), .i_brk_push(i_brk_push),
    .o_p(o_p), .o_p_push(o_p_push), .o_decimal_en(o_decimal_en)
  );

  processor_status_reg #(.HAS_DECIMAL(1'b0)) dut_nd (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en), .i_db(i_db),
    .i_acr(i_acr), .i_avr(i_avr), .i_ir5(i_ir5),
    .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c), .i_acr_c(i_acr_c),
    .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z),
    .i_db2_i(i_db2_i), .i_ir5_i(i_ir5_i), .i_set_i(i_set_i),
    .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
    .i_db6_v(i_db6_v), .i_avr_v(i_avr_v), .i_0_v(i_0_v), .i_so_n(i_so_n),
    .i_db7_n(i_db7_n), .i_brk_push(i_brk_push),
    .o_p(o_p_nd), .o_p_push(o_p_push_nd), .o_decimal_en(o_decimal_en_nd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive one cycle of stimulus, record expected and observed o_p
  task automatic step(input logic en, input logic [7:0] db, input logic [2:0] aai,
                      input logic [13:0] sel, input logic [7:0] want);
    i_clk_en = en;
    i_db     = db;
    {i_acr, i_avr, i_ir5} = aai;
    i_db0_c = sel[0];  i_ir5_c = sel[1];  i_acr_c = sel[2];
    i_db1_z = sel[3];  i_dbz_z = sel[4];
    i_db2_i = sel[5];  i_ir5_i = sel[6];  i_set_i = sel[7];
    i_db3_d = sel[8];  i_ir5_d = sel[9];
    i_db6_v = sel[10]; i_avr_v = sel[11]; i_0_v = sel[12];
    i_db7_n = sel[13];
    exp_q.push_back(want);
    @(posedge i_clk);
    #1;
    obs_q.push_back(o_p);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b1;
    #22;
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (o_p !== 8'h34) begin n_mis++; $display("FAIL reset_async_p: got %h want 34", o_p); end
    n_cmp++;
    if (o_p_push !== 8'h24) begin n_mis++; $display("FAIL reset_push: got %h want 24", o_p_push); end
    n_cmp++;
    if (o_decimal_en !== 1'b0) begin n_mis++; $display("FAIL reset_dec: got %b want 0", o_decimal_en); end
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b1, 8'h00, 3'b000, S_NONE, 8'h34);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL reset_hold: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_plp();
    step(1'b1, 8'hCF, 3'b000, S_DBALL, 8'hFF);
    n_cmp++;
    if (o_decimal_en !== 1'b1) begin n_mis++; $display("FAIL dec_en: got %b want 1", o_decimal_en); end
    n_cmp++;
    if (o_decimal_en_nd !== 1'b0) begin n_mis++; $display("FAIL nodec_en: got %b want 0", o_decimal_en_nd); end
    n_cmp++;
    if (o_p_nd !== 8'hFF) begin n_mis++; $display("FAIL nodec_p: got %h want ff", o_p_nd); end
    step(1'b1, 8'h00, 3'b000, S_DBALL, 8'h30);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL plp: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_priority();
    step(1'b1, 8'h00, 3'b100, S_C_ACR,             8'h31);
    step(1'b1, 8'h00, 3'b100, S_C_DB0 | S_C_ACR,   8'h30);
    step(1'b1, 8'h00, 3'b001, S_C_IR5,             8'h31);
    step(1'b1, 8'h00, 3'b001, S_C_ACR | S_C_IR5,   8'h30);
    step(1'b1, 8'h00, 3'b000, S_I_SET | S_I_DB2,   8'h34);
    step(1'b1, 8'h00, 3'b001, S_I_DB2 | S_I_IR5,   8'h30);
    step(1'b1, 8'h00, 3'b001, S_D_IR5,             8'h38);
    step(1'b1, 8'h00, 3'b001, S_D_DB3 | S_D_IR5,   8'h30);
    step(1'b1, 8'h00, 3'b010, S_V_AVR,             8'h70);
    step(1'b1, 8'h00, 3'b010, S_V_DB6 | S_V_AVR,   8'h30);
    step(1'b1, 8'h00, 3'b010, S_V_AVR | S_V_0,     8'h70);
    step(1'b1, 8'h00, 3'b000, S_V_0,               8'h30);
    step(1'b1, 8'h00, 3'b100, S_I_SET | S_C_ACR,   8'h35);
    step(1'b1, 8'h00, 3'b000, S_I_DB2 | S_C_DB0,   8'h30);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL priority: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_zn_clk_en();
    step(1'b1, 8'h00, 3'b000, S_Z_DBZ,             8'h32);
    step(1'b1, 8'h80, 3'b000, S_Z_DBZ,             8'h30);
    step(1'b1, 8'h02, 3'b000, S_Z_DB1 | S_Z_DBZ,   8'h32);
    step(1'b1, 8'h00, 3'b000, S_Z_DB1 | S_Z_DBZ,   8'h30);
    step(1'b1, 8'h80, 3'b000, S_N_DB7,             8'hB0);
    step(1'b1, 8'h7F, 3'b000, S_N_DB7,             8'h30);
    // Disabled cycles: everything asserted, nothing may change
    step(1'b0, 8'hCF, 3'b111, S_DBALL | S_I_SET | S_C_ACR, 8'h30);
    step(1'b0, 8'h00, 3'b111, S_Z_DBZ | S_I_SET | S_V_AVR | S_D_IR5, 8'h30);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL zn_clk_en: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_push();
    step(1'b1, 8'hC3, 3'b000, S_DBALL, 8'hF3);
    i_brk_push = 1'b1;
    #1;
    n_cmp++;
    if (o_p_push !== 8'hF3) begin n_mis++; $display("FAIL push_brk: got %h want f3", o_p_push); end
    i_brk_push = 1'b0;
    #1;
    n_cmp++;
    if (o_p_push !== 8'hE3) begin n_mis++; $display("FAIL push_irq: got %h want e3", o_p_push); end
    n_cmp++;
    if (o_p_push_nd !== 8'hE3) begin n_mis++; $display("FAIL push_nd: got %h want e3", o_p_push_nd); end
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL push_load: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_so();
    step(1'b1, 8'h00, 3'b000, S_V_0, 8'hB3);
    // First pulse while stalled
    i_so_n = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'hB3);
    i_so_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'hB3);
    step(1'b1, 8'h00, 3'b000, S_V_0,  8'hF3);
    step(1'b1, 8'h00, 3'b000, S_NONE, 8'hF3);
    step(1'b1, 8'h00, 3'b000, S_V_0,  8'hB3);
    // Second pulse after the first was consumed
    i_so_n = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'hB3);
    i_so_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'hB3);
    step(1'b1, 8'h00, 3'b000, S_V_0,  8'hF3);
    step(1'b1, 8'h00, 3'b000, S_V_0,  8'hB3);
    // Two pulses while stalled merge into one event
    for (int r = 0; r < 2; r++) begin
      i_so_n = 1'b0;
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'hB3);
      i_so_n = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'hB3);
    end
    step(1'b1, 8'h00, 3'b000, S_V_0, 8'hF3);
    step(1'b1, 8'h00, 3'b000, S_V_0, 8'hB3);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL so: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h01, 3'b000, S_DBALL, 8'h31);
    step(1'b1, 8'h80, 3'b000, S_DBALL, 8'hB0);
    step(1'b1, 8'h4C, 3'b000, S_DBALL, 8'h7C);
    step(1'b1, 8'hFF, 3'b000, S_DBALL, 8'hFF);
    step(1'b1, 8'h00, 3'b000, S_DBALL, 8'h30);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL back_to_back: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  task automatic test_reset_mid();
    // Leave an SO event pending, then reset; it must be discarded
    i_so_n = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'h30);
    i_so_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 3'b000, S_NONE, 8'h30);
    #2;
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (o_p !== 8'h34) begin n_mis++; $display("FAIL reset_mid_async: got %h want 34", o_p); end
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    step(1'b1, 8'h00, 3'b000, S_NONE, 8'h34);
    step(1'b1, 8'h00, 3'b000, S_NONE, 8'h34);
    while (exp_q.size() > 0) begin
      want_v = exp_q.pop_front(); got_v = obs_q.pop_front(); n_cmp++;
      if (got_v !== want_v) begin n_mis++; $display("FAIL reset_mid: o_p=%h want %h", got_v, want_v); end
    end
  endtask

  initial begin
    i_reset_n = 1'b1; i_clk_en = 1'b0; i_db = 8'h00;
    i_acr = 1'b0; i_avr = 1'b0; i_ir5 = 1'b0;
    i_db0_c = 1'b0; i_ir5_c = 1'b0; i_acr_c = 1'b0;
    i_db1_z = 1'b0; i_dbz_z = 1'b0;
    i_db2_i = 1'b0; i_ir5_i = 1'b0; i_set_i = 1'b0;
    i_db3_d = 1'b0; i_ir5_d = 1'b0;
    i_db6_v = 1'b0; i_avr_v = 1'b0; i_0_v = 1'b0; i_so_n = 1'b1;
    i_db7_n = 1'b0; i_brk_push = 1'b0;

    test_reset();
    test_plp();
    test_priority();
    test_zn_clk_en();
    test_push();
    test_so();
    test_back_to_back();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/processor_status_reg.md
Name: processor_status_reg

Overview:
Parametrised 6502/2A03 processor status register (P) for the cpu6502 core. It stores C, Z, I, D, V and N, each with its own set of load sources (data bus, ALU carry/overflow, IR bit 5, constants). It also builds the byte pushed to the stack (with the B bit) and the zero/negative results derived from the data bus. Every flag updates synchronously on a clock enable, replacing the earlier per-flag asynchronous latching.

Parameters:
HAS_DECIMAL, 1, 1 = D flag drives o_decimal_en; 0 (2A03) = D still stored and readable, o_decimal_en tied 0
RESET_P, 8'h04, flag values loaded on reset (bits 5/4 ignored; default sets I only)
DB_WIDTH, 8, data bus width; only 8 is legal (elaboration-time check fails otherwise)

Ports:
i_clk  in  1  core clock
i_reset_n  in  1  reset
i_clk_en  in  1  update enable (phi2 qualifier); no flag changes when 0
i_db  in  8  internal data bus value
i_acr  in  1  ALU carry out
i_avr  in  1  ALU overflow
i_ir5  in  1  IR bit 5 (SEC/CLC, SEI/CLI, SED/CLD)
i_db0_c, i_ir5_c, i_acr_c  in  1 each  C load selects
i_db1_z, i_dbz_z  in  1 each  Z from db[1] / Z = (i_db==0)
i_db2_i, i_ir5_i, i_set_i  in  1 each  I load selects; i_set_i forces I=1 (interrupt sequence)
i_db3_d, i_ir5_d  in  1 each  D load selects
i_db6_v, i_avr_v, i_0_v, i_so_n  in  1 each  V load selects; i_0_v clears (CLV); i_so_n falling edge sets V
i_db7_n  in  1  N from db[7]
i_brk_push  in  1  B value in pushed byte (1 = BRK/PHP, 0 = IRQ/NMI)
o_p  out  8  P: {N,V,1,1,D,I,Z,C}
o_p_push  out  8  {N,V,1,i_brk_push,D,I,Z,C}, for driving onto the bus on stack push
o_decimal_en  out  1  D && HAS_DECIMAL

Behaviour:
- Reset: i_reset_n asynchronous, active-low. While low, flags = RESET_P and the i_so_n edge detector is cleared to "high". Default o_p = 8'h34, o_decimal_en = 0. First update is possible on the first enabled rising edge after release.
- Update: on rising i_clk with i_clk_en=1, each flag loads from its highest-priority asserted select; otherwise it holds. Result is visible on o_p the next cycle (1-cycle latency). o_p and o_p_push are purely registered/combinational from the flags, with no bus-dependent paths except the B bit.
- C priority: i_db0_c (db[0]) > i_acr_c (i_acr) > i_ir5_c (i_ir5).
- Z priority: i_db1_z (db[1]) > i_dbz_z (db==0).
- I priority: i_set_i (1) > i_db2_i (db[2]) > i_ir5_i (i_ir5).
- D priority: i_db3_d (db[3]) > i_ir5_d (i_ir5).
- V priority: SO event (1) > i_db6_v (db[6]) > i_avr_v (i_avr) > i_0_v (0).
  - SO event is a falling edge of i_so_n, sampled by a 2-flop synchroniser plus an edge flop every i_clk, independent of i_clk_en.
  - The event is held pending until the next enabled edge, then cleared.
  - A second falling edge while an event is pending merges into it.
- N: i_db7_n loads db[7].
- Bits 5 and 4 are not stored. o_p reads them as 1. PLP data on db[5:4] is ignored.
- Simultaneous selects: the priorities above apply. Different flags update independently in the same cycle (e.g. PLP asserts all db selects at once).
- i_clk_en=0: all select inputs are ignored; only the SO pending flag can change.
- Reset mid-operation: flags return to RESET_P immediately (asynchronously) and any pending SO event is discarded.

Test Plan:
- Reset: assert i_reset_n=0 mid-cycle -> o_p=8'h34 immediately; release, no selects for 5 cycles -> o_p stays 8'h34.
- PLP: i_db=8'hCF with all db selects for one enabled cycle -> o_p=8'hFF next cycle. Then i_db=8'h00 -> o_p=8'h30 (bits 5/4 stay 1).
- Priority: i_db0_c=1, i_acr_c=1, db[0]=0, i_acr=1 -> C=0. i_set_i=1 with i_db2_i=1, db[2]=0 -> I=1.
- Z from bus: i_dbz_z=1 with i_db=8'h00 -> Z=1; i_db=8'h80 -> Z=0. i_clk_en=0 with selects asserted -> o_p unchanged.
- Push: flags=8'hC3, i_brk_push=1 -> o_p_push=8'hF3; i_brk_push=0 -> 8'hE3. HAS_DECIMAL=0 with D=1 -> o_decimal_en=0 and o_p[3]=1.
- SO: pulse i_so_n low while i_clk_en=0 for 4 cycles, with i_0_v asserted on the next enabled edge -> V=1. A second pulse after the event is consumed -> V=1 again, then i_0_v alone -> V=0.
